pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, which is the number of cycles the flush is held after a taken branch (legal range 1..7).
REQ-002 SHALL have parameter CNT_W, default 32, which is the width of the performance counters.
REQ-003 SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have ports id_rs1 and id_rs2, input, 5 bits each: ID-stage source register indices.
REQ-006 SHALL have port ex_rd, input, 5 bits: EX-stage destination register index.
REQ-007 SHALL have port ex_mem_read, input, 1 bit: the EX-stage instruction is a load.
REQ-008 SHALL have port branch_taken, input, 1 bit: a taken branch or jalr is resolved in EX.
REQ-009 SHALL have ports imem_ready and dmem_ready, input, 1 bit each: the instruction and data memories can complete this cycle.
REQ-010 SHALL have ports pc_stall, if_id_stall and ex_mem_stall, output, 1 bit each: hold the corresponding register.
REQ-011 SHALL have ports if_id_flush and id_ex_flush, output, 1 bit each: load a bubble into the corresponding pipeline register.
REQ-012 SHALL have port state, output, 2 bits: the current FSM state.
REQ-013 SHALL have ports stall_cycles and flush_events, output, CNT_W bits each: performance counters.

Function
REQ-014 SHALL implement FSM states RUN=0, FLUSH=1, MEM_WAIT=2; encoding 3 is unreachable and SHALL recover to RUN on the next edge.
REQ-015 SHALL define load_use as ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
REQ-016 SHALL, in RUN, apply this priority: !dmem_ready > branch_taken > load_use > !imem_ready.
REQ-017 SHALL, in RUN with !dmem_ready, assert pc_stall, if_id_stall and ex_mem_stall combinationally with no flush, and enter MEM_WAIT.
REQ-018 SHALL, in RUN with branch_taken, assert if_id_flush and id_ex_flush the same cycle, not stall the PC, and enter FLUSH with the counter at FLUSH_CYCLES-1; if FLUSH_CYCLES==1, it SHALL stay in RUN instead.
REQ-019 SHALL, in RUN with load_use, assert pc_stall, if_id_stall and id_ex_flush for one cycle and remain in RUN.
REQ-020 SHALL, in RUN with !imem_ready only, assert pc_stall and if_id_flush.
REQ-021 SHALL, in FLUSH, assert if_id_flush and id_ex_flush, decrement the counter, ignore branch_taken and load_use, and return to RUN after the counter reaches 0.
REQ-022 SHALL, in FLUSH with !dmem_ready, assert all stalls, suppress flushes, and freeze the counter.
REQ-023 SHALL, in MEM_WAIT, assert all stalls and ignore branch_taken and load_use.
REQ-024 SHALL, on the first MEM_WAIT cycle with dmem_ready, deassert all stalls combinationally and return to RUN next edge.
REQ-025 SHALL keep every stall and flush output combinationally 0 while reset is high.

Reset
REQ-026 SHALL, on reset, set state to RUN, the flush counter to 0, and both performance counters to 0.
REQ-027 SHALL, on reset mid-FLUSH or mid-MEM_WAIT, go to RUN on the next edge, discarding any pending flush.

Configuration
REQ-028 SHALL, with PIPE_PERF_CNT_EN defined, increment stall_cycles on each cycle with pc_stall=1 and increment flush_events on each RUN-to-FLUSH entry or FLUSH_CYCLES==1 branch, both saturating at all-ones.
REQ-029 SHALL, without PIPE_PERF_CNT_EN, tie both counter outputs to 0 and instantiate no counter flops.

Structure
REQ-030 SHALL place the state enum, REG_IDX_W=5, and the reset PC constant 32'h0040_0000 in the shared package pipe_ctrl_pkg.
REQ-031 SHALL place the load_use comparator in the combinational sub-module load_use_detect.

Verification
REQ-032 SHALL cover: ex_mem_read=1, ex_rd=5, id_rs2=5 -> pc_stall=if_id_stall=id_ex_flush=1 for exactly 1 cycle, state=RUN.
REQ-033 SHALL cover: same as REQ-032 but ex_rd=0 -> no stall and no flush.
REQ-034 SHALL cover: FLUSH_CYCLES=3, branch_taken pulse -> flushes high for 3 consecutive cycles, flush_events=1, then state=RUN.
REQ-035 SHALL cover: dmem_ready=0 for 4 cycles while branch_taken=1 -> all stalls high for 4 cycles with no flush; the flush starts the cycle after release.
REQ-036 SHALL cover: reset asserted during the 2nd FLUSH cycle -> outputs 0 immediately, state=RUN and counters 0 after the edge.
REQ-037 SHALL cover: load_use and branch_taken both asserted in RUN -> branch wins, with no pc_stall and both flushes high.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/flush controller.
// Imported by the interface, the load-use detector and the controller top.
package pipe_ctrl_pkg;

  localparam int REG_IDX_W   = 5;
  localparam int FLUSH_CNT_W = 3;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } pipe_state_t;

  // Every stall/flush strobe the controller drives, as one bundle.
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic ex_mem_stall;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_IDLE      = 5'b00000;
  localparam ctrl_out_t CTRL_ALL_STALL = 5'b11100;
  localparam ctrl_out_t CTRL_FLUSH     = 5'b00011;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/control bundle between the pipeline datapath (master) and the
// pipeline controller (slave).
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipe_ctrl_pkg::*;

  logic [REG_IDX_W-1:0] id_rs1;
  logic [REG_IDX_W-1:0] id_rs2;
  logic [REG_IDX_W-1:0] ex_rd;
  logic                 ex_mem_read;
  logic                 branch_taken;
  logic                 imem_ready;
  logic                 dmem_ready;

  logic                 pc_stall;
  logic                 if_id_stall;
  logic                 ex_mem_stall;
  logic                 if_id_flush;
  logic                 id_ex_flush;
  logic [1:0]           state;
  logic [CNT_W-1:0]     stall_cycles;
  logic [CNT_W-1:0]     flush_events;

  modport master (
    output id_rs1, id_rs2, ex_rd, ex_mem_read, branch_taken, imem_ready, dmem_ready,
    input  pc_stall, if_id_stall, ex_mem_stall, if_id_flush, id_ex_flush,
    input  state, stall_cycles, flush_events
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rd, ex_mem_read, branch_taken, imem_ready, dmem_ready,
    output pc_stall, if_id_stall, ex_mem_stall, if_id_flush, id_ex_flush,
    output state, stall_cycles, flush_events
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: the EX load's destination matches
// either ID source register (x0 never creates a hazard).
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  output logic                 load_use
);

  logic [REG_IDX_W-1:0] src [2];
  logic [1:0]           hit;

  assign src[0] = id_rs1;
  assign src[1] = id_rs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign hit[gi] = (ex_rd == src[gi]);
    end
  endgenerate

  assign load_use = ex_mem_read && (ex_rd != '0) && (|hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: RUN / FLUSH / MEM_WAIT FSM.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic           clock,
  input  logic           reset,
  pipeline_ctrl_if.slave bus
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  pipe_state_t            state_reg;
  pipe_state_t            state_next;
  logic [FLUSH_CNT_W-1:0] cnt_reg;
  logic [FLUSH_CNT_W-1:0] cnt_next;
  logic                   load_use;
  ctrl_out_t              ctrl;

  load_use_detect u_load_use_detect (
    .ex_mem_read (bus.ex_mem_read),
    .ex_rd       (bus.ex_rd),
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .load_use    (load_use)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      RUN: begin
        if (!bus.dmem_ready) begin
          state_next = MEM_WAIT;
        end else if (bus.branch_taken && (FLUSH_CYCLES > 1)) begin
          state_next = FLUSH;
          cnt_next   = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        // The branch cycle itself was the first flush, so leave when the
        // decremented count hits zero; a data stall freezes the count.
        if (bus.dmem_ready) begin
          if (cnt_reg <= FLUSH_CNT_W'(1)) begin
            state_next = RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg - FLUSH_CNT_W'(1);
          end
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ready) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    ctrl = CTRL_IDLE;
    if (!reset) begin
      case (state_reg)
        RUN: begin
          if (!bus.dmem_ready) begin
            ctrl = CTRL_ALL_STALL;
          end else if (bus.branch_taken) begin
            ctrl = CTRL_FLUSH;
          end else if (load_use) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_stall = 1'b1;
            ctrl.id_ex_flush = 1'b1;
          end else if (!bus.imem_ready) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_flush = 1'b1;
          end
        end
        FLUSH:    ctrl = bus.dmem_ready ? CTRL_FLUSH : CTRL_ALL_STALL;
        MEM_WAIT: ctrl = bus.dmem_ready ? CTRL_IDLE : CTRL_ALL_STALL;
        default:  ctrl = CTRL_IDLE;
      endcase
    end
  end

  assign bus.pc_stall     = ctrl.pc_stall;
  assign bus.if_id_stall  = ctrl.if_id_stall;
  assign bus.ex_mem_stall = ctrl.ex_mem_stall;
  assign bus.if_id_flush  = ctrl.if_id_flush;
  assign bus.id_ex_flush  = ctrl.id_ex_flush;
  assign bus.state        = state_reg;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_reg;
  logic [CNT_W-1:0] flush_events_reg;
  logic             flush_entry;

  // A branch accepted in RUN counts once, whether or not FLUSH is entered.
  assign flush_entry = (state_reg == RUN) && bus.dmem_ready && bus.branch_taken;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles_reg <= '0;
      flush_events_reg <= '0;
    end else begin
      if (ctrl.pc_stall && (stall_cycles_reg != {CNT_W{1'b1}})) begin
        stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
      end
      if (flush_entry && (flush_events_reg != {CNT_W{1'b1}})) begin
        flush_events_reg <= flush_events_reg + CNT_W'(1);
      end
    end
  end

  assign bus.stall_cycles = stall_cycles_reg;
  assign bus.flush_events = flush_events_reg;
`else
  assign bus.stall_cycles = {CNT_W{1'b0}};
  assign bus.flush_events = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl (FLUSH_CYCLES=3): directed vectors with literal
// expectations plus a per-cycle behavioural model comparison.
module tb_pipeline_ctrl;

  localparam int FC = 3;
  localparam int CW = 32;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  pipeline_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_ctrl #(
    .FLUSH_CYCLES (FC),
    .CNT_W        (CW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] got_out();
    return {bus.pc_stall, bus.if_id_stall, bus.ex_mem_stall, bus.if_id_flush, bus.id_ex_flush};
  endfunction

  // Behavioural model: "waiting on data memory" flag and number of flush
  // cycles still owed after the branch cycle, plus running event totals.
  bit m_wait = 1'b0, nx_wait = 1'b0;
  int m_left = 0, nx_left = 0;
  int m_stalls = 0, nx_stalls = 0;
  int m_flushes = 0, nx_flushes = 0;

  always @(negedge clock) begin : compare
    logic [4:0] e;
    logic [1:0] es;
    bit         lu;
    es = m_wait ? 2'd2 : ((m_left > 0) ? 2'd1 : 2'd0);
    e  = 5'b00000;
    nx_wait = m_wait; nx_left = m_left; nx_stalls = m_stalls; nx_flushes = m_flushes;
    lu = bus.ex_mem_read && (bus.ex_rd != 0) &&
         ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));
    if (reset) begin
      nx_wait = 1'b0; nx_left = 0; nx_stalls = 0; nx_flushes = 0;
    end else begin
      if (m_wait) begin
        if (!bus.dmem_ready) e = 5'b11100;
        else nx_wait = 1'b0;
      end else if (m_left > 0) begin
        if (!bus.dmem_ready) e = 5'b11100;
        else begin e = 5'b00011; nx_left = m_left - 1; end
      end else begin
        if (!bus.dmem_ready) begin e = 5'b11100; nx_wait = 1'b1; end
        else if (bus.branch_taken) begin e = 5'b00011; nx_left = FC - 1; nx_flushes++; end
        else if (lu) e = 5'b11001;
        else if (!bus.imem_ready) e = 5'b10010;
      end
      if (e[4]) nx_stalls++;
    end
    chk("model_out", 32'(got_out()), 32'(e));
    chk("model_state", 32'(bus.state), 32'(es));
    chk("model_stall_cycles", bus.stall_cycles, PERF ? m_stalls : 0);
    chk("model_flush_events", bus.flush_events, PERF ? m_flushes : 0);
  end

  always @(posedge clock) begin
    m_wait    <= nx_wait;
    m_left    <= nx_left;
    m_stalls  <= nx_stalls;
    m_flushes <= nx_flushes;
  end

  task automatic vec(input string nm, input bit rst, input bit mr, input logic [4:0] rd,
                     input logic [4:0] rs2, input bit br, input bit im, input bit dm,
                     input logic [4:0] exp, input logic [1:0] est);
    @(posedge clock);
    #1;
    reset = rst; bus.ex_mem_read = mr; bus.ex_rd = rd; bus.id_rs2 = rs2;
    bus.branch_taken = br; bus.imem_ready = im; bus.dmem_ready = dm;
    @(negedge clock);
    chk({nm, "_out"}, 32'(got_out()), 32'(exp));
    chk({nm, "_state"}, 32'(bus.state), 32'(est));
    $display("[TB] %-12s rst=%0b mr=%0b rd=%0d rs2=%0d br=%0b im=%0b dm=%0b -> out=%05b state=%0d",
             nm, rst, mr, rd, rs2, br, im, dm, got_out(), bus.state);
  endtask

  initial begin
    bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd2; bus.ex_rd = 5'd3; bus.ex_mem_read = 1'b0;
    bus.branch_taken = 1'b0; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
    //   name           rst mr rd  rs2 br im dm  out        state
    vec("reset",         1, 0, 3,  2,  0, 1, 1, 5'b00000, 2'd0);
    vec("reset_mask",    1, 1, 2,  2,  1, 0, 0, 5'b00000, 2'd0);
    vec("idle",          0, 0, 3,  2,  0, 1, 1, 5'b00000, 2'd0);
    vec("lu_rs2",        0, 1, 5,  5,  0, 1, 1, 5'b11001, 2'd0);
    vec("lu_gone",       0, 0, 5,  5,  0, 1, 1, 5'b00000, 2'd0);
    vec("lu_rd0",        0, 1, 0,  5,  0, 1, 1, 5'b00000, 2'd0);
    vec("lu_rd0_rs0",    0, 1, 0,  0,  0, 1, 1, 5'b00000, 2'd0);
    vec("lu_rs1",        0, 1, 1,  2,  0, 1, 1, 5'b11001, 2'd0);
    vec("no_load",       0, 0, 5,  5,  0, 1, 1, 5'b00000, 2'd0);
    vec("imem_wait",     0, 0, 3,  2,  0, 0, 1, 5'b10010, 2'd0);
    vec("lu_over_imem",  0, 1, 5,  5,  0, 0, 1, 5'b11001, 2'd0);
    vec("br_over_lu",    0, 1, 5,  5,  1, 1, 1, 5'b00011, 2'd0);
    vec("flush1_ign",    0, 1, 5,  5,  1, 1, 1, 5'b00011, 2'd1);
    vec("flush2",        0, 0, 3,  2,  0, 1, 1, 5'b00011, 2'd1);
    vec("flush_done",    0, 0, 3,  2,  0, 1, 1, 5'b00000, 2'd0);
    chk("flush_events_after_branch", bus.flush_events, PERF ? 32'd1 : 32'd0);
    chk("stall_cycles_after_branch", bus.stall_cycles, PERF ? 32'd4 : 32'd0);
    vec("dstall_br1",    0, 0, 3,  2,  1, 1, 0, 5'b11100, 2'd0);
    vec("dstall_br2",    0, 0, 3,  2,  1, 1, 0, 5'b11100, 2'd2);
    vec("dstall_br3",    0, 0, 3,  2,  1, 1, 0, 5'b11100, 2'd2);
    vec("dstall_br4",    0, 0, 3,  2,  1, 1, 0, 5'b11100, 2'd2);
    vec("dmem_release",  0, 0, 3,  2,  1, 1, 1, 5'b00000, 2'd2);
    vec("br_after_rel",  0, 0, 3,  2,  1, 1, 1, 5'b00011, 2'd0);
    vec("flush_dstall1", 0, 0, 3,  2,  0, 1, 0, 5'b11100, 2'd1);
    vec("flush_dstall2", 0, 0, 3,  2,  0, 1, 0, 5'b11100, 2'd1);
    vec("flush_resume1", 0, 0, 3,  2,  0, 1, 1, 5'b00011, 2'd1);
    vec("flush_resume2", 0, 0, 3,  2,  0, 0, 1, 5'b00011, 2'd1);
    vec("flush_exit",    0, 0, 3,  2,  0, 1, 1, 5'b00000, 2'd0);
    vec("br_again",      0, 0, 3,  2,  1, 1, 1, 5'b00011, 2'd0);
    vec("flush_c1",      0, 0, 3,  2,  0, 1, 1, 5'b00011, 2'd1);
    vec("rst_in_flush",  1, 0, 3,  2,  0, 1, 1, 5'b00000, 2'd1);
    vec("after_rst",     0, 0, 3,  2,  0, 1, 1, 5'b00000, 2'd0);
    chk("stall_cycles_after_reset", bus.stall_cycles, 32'd0);
    chk("flush_events_after_reset", bus.flush_events, 32'd0);
    vec("mw_enter",      0, 0, 3,  2,  0, 1, 0, 5'b11100, 2'd0);
    vec("mw_hold",       0, 1, 5,  5,  1, 1, 0, 5'b11100, 2'd2);
    vec("rst_in_mw",     1, 0, 3,  2,  0, 1, 0, 5'b00000, 2'd2);
    vec("after_rst_mw",  0, 0, 3,  2,  0, 1, 1, 5'b00000, 2'd0);
    vec("final_lu",      0, 1, 2,  2,  0, 1, 1, 5'b11001, 2'd0);
    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
